// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised pipeline stage register with a 2-entry skid buffer. Carries a
// DATA_W-bit payload and a CTRL_W-bit control bundle between pipeline stages
// using a valid/ready handshake. It supports stall by backpressure, synchronous
// flush with bubble insertion, and a saturating count of squashed entries.
//
// Parameters
//   DATA_W : payload width
//   CTRL_W : control bundle width
//   CNT_W  : drop counter width
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   in_valid_i   : upstream entry valid
//   in_ready_o   : stage can accept an entry (straight from a flop)
//   in_data_i    : upstream payload
//   in_ctrl_i    : upstream control bundle
//   out_valid_o  : head entry valid
//   out_ready_i  : downstream accepts (low = stall)
//   out_data_o   : head payload
//   out_ctrl_o   : head control bundle, zero whenever out_valid_o is low
//   flush_i      : squash held entries and the incoming entry this cycle
//   count_o      : occupancy 0..2
//   drop_cnt_o   : saturating count of entries squashed by flush
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    input  logic              flush_i,
    output logic [1:0]        count_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    // The encoding equals the occupancy so count_o is the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q,  in_ready_d;
    logic [CNT_W-1:0]  drop_cnt_q,  drop_cnt_d;

    logic              in_fire_s;
    logic              out_fire_s;
    logic [1:0]        dropped_s;
    logic [CNT_W:0]    drop_sum_s;

    // Handshake qualifiers and flush accounting.
    always_comb begin
        in_fire_s  = in_valid_i & in_ready_q;
        out_fire_s = (state_q != ST_EMPTY) & out_ready_i;
        // Entries lost in a flush: everything held, minus the one delivered
        // this cycle, plus the one that would have been accepted.
        dropped_s  = 2'(state_q) - {1'b0, out_fire_s} + {1'b0, in_fire_s};
        // One extra bit catches overflow so the counter can saturate.
        drop_sum_s = {1'b0, drop_cnt_q} + (CNT_W+1)'(dropped_s);
    end

    // Next-state, storage update and drop counter.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        drop_cnt_d  = drop_cnt_q;

        if (flush_i) begin
            // Data registers keep stale contents; the ctrl gate on the output
            // turns the emptied stage into a bubble.
            state_d = ST_EMPTY;
            if (drop_sum_s[CNT_W]) begin
                drop_cnt_d = '1;
            end else begin
                drop_cnt_d = drop_sum_s[CNT_W-1:0];
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d     = ST_ONE;
                        head_data_d = in_data_i;
                        head_ctrl_d = in_ctrl_i;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && !out_fire_s) begin
                        state_d     = ST_FULL;
                        skid_data_d = in_data_i;
                        skid_ctrl_d = in_ctrl_i;
                    end else if (in_fire_s && out_fire_s) begin
                        state_d     = ST_ONE;
                        head_data_d = in_data_i;
                        head_ctrl_d = in_ctrl_i;
                    end else if (out_fire_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready_q is low here, so only the drain can happen.
                    if (out_fire_s) begin
                        state_d     = ST_ONE;
                        head_data_d = skid_data_q;
                        head_ctrl_d = skid_ctrl_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage.
                    state_d = ST_EMPTY;
                end
            endcase
        end

        // Registered ready: no combinational path from out_ready_i.
        in_ready_d = (state_d != ST_FULL);
    end

    // State and storage registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            head_data_q <= '0;
            head_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = head_data_q;
    assign out_ctrl_o  = (state_q != ST_EMPTY) ? head_ctrl_q : {CTRL_W{1'b0}};
    assign count_o     = state_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg. Two instances share all inputs: one
// with default parameters and one with a 2-bit drop counter for saturation.
// A queue-based reference model (capacity 2, FIFO order, flush clears it)
// predicts every output.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 5;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_ready;
    logic              flush;

    logic              a_in_ready, a_out_valid;
    logic [DATA_W-1:0] a_out_data;
    logic [CTRL_W-1:0] a_out_ctrl;
    logic [1:0]        a_count;
    logic [15:0]       a_drop;

    logic              b_in_ready, b_out_valid;
    logic [DATA_W-1:0] b_out_data;
    logic [CTRL_W-1:0] b_out_ctrl;
    logic [1:0]        b_count;
    logic [1:0]        b_drop;

    pipe_stage_reg u_dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready),
        .out_data_o(a_out_data), .out_ctrl_o(a_out_ctrl),
        .flush_i(flush), .count_o(a_count), .drop_cnt_o(a_drop)
    );

    pipe_stage_reg #(.CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(b_in_ready),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready),
        .out_data_o(b_out_data), .out_ctrl_o(b_out_ctrl),
        .flush_i(flush), .count_o(b_count), .drop_cnt_o(b_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } ent_t;

    ent_t q[$];
    int   drop_a;
    int   drop_b;
    int   checks;
    int   errors;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare both instances against the model's current contents.
    task automatic check_outputs();
        logic              v;
        logic [CTRL_W-1:0] c;
        v = (q.size() > 0);
        c = v ? q[0].c : 5'd0;
        chk("a_in_ready", 128'(a_in_ready), 128'(q.size() < 2));
        chk("a_out_valid", 128'(a_out_valid), 128'(v));
        chk("a_count", 128'(a_count), 128'(q.size()));
        chk("a_out_ctrl", 128'(a_out_ctrl), 128'(c));
        chk("a_drop", 128'(a_drop), 128'(drop_a));
        chk("b_in_ready", 128'(b_in_ready), 128'(q.size() < 2));
        chk("b_out_valid", 128'(b_out_valid), 128'(v));
        chk("b_count", 128'(b_count), 128'(q.size()));
        chk("b_out_ctrl", 128'(b_out_ctrl), 128'(c));
        chk("b_drop", 128'(b_drop), 128'(drop_b));
        if (v) begin
            chk("a_out_data", 128'(a_out_data), 128'(q[0].d));
            chk("b_out_data", 128'(b_out_data), 128'(q[0].d));
        end
    endtask

    // Check, advance one clock, then apply the spec rules to the model.
    task automatic cycle();
        bit   in_fire;
        bit   out_fire;
        int   lost;
        ent_t e;
        check_outputs();
        in_fire  = in_valid && (q.size() < 2);
        out_fire = out_ready && (q.size() > 0);
        e.d = in_data;
        e.c = in_ctrl;
        @(posedge clk);
        #1;
        if (flush) begin
            lost   = q.size() - int'(out_fire) + int'(in_fire);
            drop_a = (drop_a + lost > 65535) ? 65535 : drop_a + lost;
            drop_b = (drop_b + lost > 3) ? 3 : drop_b + lost;
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(e);
        end
    endtask

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit rdy, input bit fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = 5'(d[4:0] | 5'd1);
        out_ready = rdy;
        flush     = fl;
    endtask

    initial begin
        int sat_exp[3];
        sat_exp = '{2, 3, 3};
        checks = 0;
        errors = 0;
        drop_a = 0;
        drop_b = 0;
        rst = 1'b1;
        drive(1'b0, 96'd0, 1'b0, 1'b0);

        // Reset values while reset is held.
        #12;
        check_outputs();
        chk("rst_a_data", 128'(a_out_data), 128'd0);
        chk("rst_b_data", 128'(b_out_data), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming 1..8 with out_ready high.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 96'(i), 1'b1, 1'b0);
            cycle();
            chk("stream_data", 128'(a_out_data), 128'(i));
            chk("stream_count", 128'(a_count), 128'd1);
        end
        drive(1'b0, 96'd0, 1'b1, 1'b0);
        cycle();

        // Stall/skid: A, B accepted, C held upstream.
        drive(1'b1, 96'hA, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 96'hB, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 96'hC, 1'b0, 1'b0);
        cycle();
        chk("skid_count", 128'(a_count), 128'd2);
        chk("skid_ready", 128'(a_in_ready), 128'd0);
        chk("skid_head", 128'(a_out_data), 128'hA);
        drive(1'b1, 96'hC, 1'b1, 1'b0);
        cycle();
        chk("drain_b", 128'(a_out_data), 128'hB);
        cycle();
        chk("drain_c", 128'(a_out_data), 128'hC);
        drive(1'b0, 96'd0, 1'b1, 1'b0);
        cycle();

        // Flush while FULL, incoming blocked: +2.
        drive(1'b1, 96'h11, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 96'h12, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 96'h13, 1'b0, 1'b1);
        cycle();
        chk("flushfull_count", 128'(a_count), 128'd0);
        chk("flushfull_ctrl", 128'(a_out_ctrl), 128'd0);
        chk("flushfull_drop", 128'(a_drop), 128'd2);

        // Flush in ONE with in_fire and out_fire: +1.
        drive(1'b1, 96'h21, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 96'h22, 1'b1, 1'b1);
        cycle();
        chk("flushone_drop", 128'(a_drop), 128'd3);
        chk("flushone_valid", 128'(a_out_valid), 128'd0);
        chk("flushone_ready", 128'(a_in_ready), 128'd1);

        // Asynchronous reset mid-cycle while FULL.
        drive(1'b1, 96'h31, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 96'h32, 1'b0, 1'b0);
        cycle();
        chk("pre_rst_count", 128'(a_count), 128'd2);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        drop_a = 0;
        drop_b = 0;
        check_outputs();
        chk("arst_a_data", 128'(a_out_data), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 96'h5, 1'b0, 1'b0);
        cycle();
        chk("post_rst_valid", 128'(a_out_valid), 128'd1);
        chk("post_rst_data", 128'(a_out_data), 128'h5);
        drive(1'b0, 96'd0, 1'b1, 1'b0);
        cycle();

        // Saturation of the 2-bit counter: 2, 3, 3.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 96'(8'h40 + k), 1'b0, 1'b0);
            cycle();
            drive(1'b1, 96'(8'h50 + k), 1'b0, 1'b0);
            cycle();
            drive(1'b0, 96'd0, 1'b0, 1'b1);
            cycle();
            chk("sat_drop", 128'(b_drop), 128'(sat_exp[k]));
        end

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom},
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
            in_ctrl = 5'($urandom);
            cycle();
        end
        drive(1'b0, 96'd0, 1'b0, 1'b0);
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the five-stage datapath. It is the generalised replacement for the fixed inter-stage latches and is instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). The block carries a DATA_W-bit datapath payload and a CTRL_W-bit control bundle through a 2-entry skid buffer with a valid/ready handshake. It adds stall via backpressure, synchronous flush with bubble insertion, and a saturating count of squashed entries.

## Interface

**Parameters**
- DATA_W, default 96: payload width (e.g. pc, ALU result, store data).
- CTRL_W, default 5: control bundle width (RegWrite, MemToReg, MemWrite, IsBranch, IsJump).
- CNT_W, default 16: width of the drop counter.

**Ports**
- clk_i, input, 1: single clock; all state updates on the rising edge.
- rst_i, input, 1: asynchronous, active-high reset.
- in_valid_i, input, 1: upstream entry valid.
- in_ready_o, output, 1: stage can accept an entry; driven directly from a register.
- in_data_i, input, DATA_W: upstream payload.
- in_ctrl_i, input, CTRL_W: upstream control bundle.
- out_valid_o, output, 1: held entry valid.
- out_ready_i, input, 1: downstream accepts; low means stall.
- out_data_o, output, DATA_W: head payload.
- out_ctrl_o, output, CTRL_W: head control bundle; forced to 0 whenever out_valid_o=0.
- flush_i, input, 1: squash all held entries and the incoming entry this cycle.
- count_o, output, 2: occupancy, 0 to 2.
- drop_cnt_o, output, CNT_W: saturating count of entries squashed by flush.

## Operation

**Storage:** head register (data, ctrl) and skid register (data, ctrl). Occupancy state takes one of three values: EMPTY=0, ONE=1, FULL=2.

**Handshake signals**
- in_fire = in_valid_i & in_ready_o.
- out_fire = out_valid_o & out_ready_i.
- in_ready_o = (state != FULL). It has no combinational path from out_ready_i.
- out_valid_o = (state != EMPTY). out_data_o is the head register.

**Transitions when flush_i=0**
- EMPTY, in_fire → ONE; head <= in.
- ONE, in_fire & !out_fire → FULL; skid <= in.
- ONE, in_fire & out_fire → ONE; head <= in.
- ONE, !in_fire & out_fire → EMPTY.
- FULL, out_fire → ONE; head <= skid. in_fire is impossible in FULL.
- Otherwise, hold. Held entries never change while stalled.

**Flush (flush_i=1)**
- state <= EMPTY regardless of other inputs.
- An incoming in_fire entry is discarded.
- An entry that completes out_fire in the flush cycle counts as delivered, not dropped.
- dropped = state − out_fire + in_fire, range 0..2.
- drop_cnt_o <= min(drop_cnt_o + dropped, 2^CNT_W − 1). The counter saturates and does not wrap.
- Data registers may keep stale contents, but out_ctrl_o reads 0, so a bubble carries no RegWrite or MemWrite.

**Ordering:** entries leave in acceptance order. No duplication, no loss except by flush.

## Timing

- Latency: an entry accepted at edge N is visible on out_* after edge N when the stage was EMPTY. Otherwise it is visible after older entries drain.
- Throughput: 1 entry/cycle when out_ready_i is held high.
- After out_ready_i falls, the stage still accepts one more entry, because in_ready_o deasserts one cycle later via the FULL state.
- Reset values, applied asynchronously and held while rst_i=1:
  - state EMPTY
  - out_valid_o 0, out_data_o 0, out_ctrl_o 0
  - in_ready_o 1
  - count_o 0
  - drop_cnt_o 0
  - skid register 0
- Reset mid-operation discards all entries without incrementing drop_cnt_o.
- Release of rst_i is synchronised externally. The first possible accept is the first rising edge with rst_i=0.
- flush_i takes effect at the edge it is sampled. The next cycle shows out_valid_o=0, in_ready_o=1, count_o=0.

## Test plan

- **Streaming:** out_ready_i=1; feed data 0x1..0x8 on consecutive cycles → same sequence on out_data_o, one cycle latency, in_ready_o constantly 1, count_o=1.
- **Stall/skid:**
  - Feed 0xA, 0xB, 0xC with out_ready_i=0 from cycle 1 → 0xA in head, 0xB in skid, count_o=2, in_ready_o=0, 0xC held upstream.
  - Release out_ready_i → outputs 0xA, 0xB, 0xC in order.
- **Flush while FULL with incoming blocked:** state FULL, flush_i=1, out_ready_i=0 → next cycle count_o=0, out_ctrl_o=0, drop_cnt_o +2.
- **Flush in ONE with simultaneous in_fire and out_fire:** → head delivered, incoming dropped, drop_cnt_o +1, stage EMPTY.
- **Saturation:** CNT_W=2; repeat FULL-then-flush three times → drop_cnt_o sequence 2, 3, 3.
- **Async reset mid-stream:** assert rst_i between edges while FULL → outputs reach reset values immediately, without waiting for a clock edge; drop_cnt_o=0. Deassert and stream 0x5 → it appears after one edge.
